// File: rtl/fpu_seq_if.sv
// Memory and FP functional-unit port bundle for fpu_seq.
// The master side is the sequencer; the slave side is the memory / FU.
interface fpu_seq_if #(
    parameter int DW = 32
);
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          fu_start;
    logic [1:0]    fu_func_o;
    logic [DW-1:0] fu_a;
    logic [DW-1:0] fu_b;
    logic          fu_done;
    logic [DW-1:0] fu_result;
    logic [4:0]    fu_flags;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        output fu_start, fu_func_o, fu_a, fu_b,
        input  mem_rdata, mem_ready,
        input  fu_done, fu_result, fu_flags
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        input  fu_start, fu_func_o, fu_a, fu_b,
        output mem_rdata, mem_ready,
        output fu_done, fu_result, fu_flags
    );
endinterface

// File: rtl/fpu_seq.sv
// Single-issue FP instruction sequencer: FLW, FSW, FU arithmetic, FMV moves.
// Handshakes: mem_re/mem_we are one-cycle request pulses; the request is
// acknowledged by mem_ready while in MEM_WAIT (ignored elsewhere). fu_start is
// a one-cycle launch pulse; the result is taken on fu_done while in FU_WAIT
// (ignored elsewhere). All strobes and pulses are registered.
module fpu_seq #(
    parameter int DW            = 32,
    parameter int RA            = 5,
    parameter int MEM_TIMEOUT   = 16,
    parameter int LD_SAMPLE_DLY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enabled,
    input  logic [2:0]    op,
    input  logic [1:0]    fu_func,
    input  logic [DW-1:0] reg_rs1,
    input  logic [DW-1:0] freg_rs1,
    input  logic [DW-1:0] freg_rs2,
    input  logic [DW-1:0] imm,
    input  logic [RA-1:0] rd_addr,
    input  logic [RA-1:0] frd_addr,
    fpu_seq_if.master     bus,
    input  logic          fflags_clr,
    output logic [4:0]    fflags_acc,
    output logic          freg_wb_en,
    output logic [RA-1:0] freg_wb_addr,
    output logic [DW-1:0] freg_wb_data,
    output logic          reg_wb_en,
    output logic [RA-1:0] reg_wb_addr,
    output logic [DW-1:0] reg_wb_data,
    output logic          completed,
    output logic          mem_err,
    output logic          illegal,
    output logic          busy,
    output logic [3:0]    state_dbg
);
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_FLW     = 3'd1;
    localparam logic [2:0] OP_FSW     = 3'd2;
    localparam logic [2:0] OP_FARITH  = 3'd3;
    localparam logic [2:0] OP_FMV_X_W = 3'd4;
    localparam logic [2:0] OP_FMV_W_X = 3'd5;

    localparam int         TW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [3:0] LD_LAST  = (LD_SAMPLE_DLY == 0) ? 4'd0 : 4'(LD_SAMPLE_DLY - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_LD_DLY, S_FU_START,
        S_FU_WAIT, S_WB, S_DONE, S_ERR
    } state_t;

    state_t        state, state_n;
    logic [2:0]    op_q;
    logic [RA-1:0] frd_q;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    ld_cnt;

    logic [DW-1:0] mem_addr_q, mem_wdata_q, fu_a_q, fu_b_q;
    logic [1:0]    fu_func_q;
    logic          mem_re_q, mem_we_q, fu_start_q;

    logic accept, ld_sample, fu_take, fmv_f, fmv_x;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.fu_start  = fu_start_q;
    assign bus.fu_func_o = fu_func_q;
    assign bus.fu_a      = fu_a_q;
    assign bus.fu_b      = fu_b_q;

    // Next-state logic and one-cycle event decode.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        ld_sample = 1'b0;
        fu_take   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enabled && op != OP_NOP) begin
                    accept = 1'b1;
                    case (op)
                        OP_FLW, OP_FSW:         state_n = S_MEM_REQ;
                        OP_FARITH:              state_n = S_FU_START;
                        OP_FMV_X_W, OP_FMV_W_X: state_n = S_WB;
                        default:                state_n = S_DONE;
                    endcase
                end
            end
            S_MEM_REQ: state_n = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    if (op_q == OP_FSW) begin
                        state_n = S_DONE;
                    end else if (LD_SAMPLE_DLY == 0) begin
                        state_n   = S_WB;
                        ld_sample = 1'b1;
                    end else begin
                        state_n = S_LD_DLY;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_LD_DLY: begin
                if (ld_cnt == LD_LAST) begin
                    state_n   = S_WB;
                    ld_sample = 1'b1;
                end
            end
            S_FU_START: state_n = S_FU_WAIT;
            S_FU_WAIT: begin
                if (bus.fu_done) begin
                    state_n = S_WB;
                    fu_take = 1'b1;
                end
            end
            S_WB, S_DONE, S_ERR: state_n = S_IDLE;
            default:             state_n = S_IDLE;
        endcase
    end

    assign fmv_f = accept && (op == OP_FMV_W_X);
    assign fmv_x = accept && (op == OP_FMV_X_W);

    // State register, wait counters and registered strobes/pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            ld_cnt     <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            fu_start_q <= 1'b0;
            freg_wb_en <= 1'b0;
            reg_wb_en  <= 1'b0;
            completed  <= 1'b0;
            mem_err    <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_n;
            tmo_cnt    <= (state == S_MEM_WAIT && state_n == S_MEM_WAIT) ? tmo_cnt + 1'b1 : '0;
            ld_cnt     <= (state == S_LD_DLY && state_n == S_LD_DLY) ? ld_cnt + 4'd1 : 4'd0;
            mem_re_q   <= accept && (op == OP_FLW);
            mem_we_q   <= accept && (op == OP_FSW);
            fu_start_q <= accept && (op == OP_FARITH);
            freg_wb_en <= ld_sample || fu_take || fmv_f;
            reg_wb_en  <= fmv_x;
            completed  <= (state_n == S_WB) || (state_n == S_DONE) || (state_n == S_ERR);
            mem_err    <= (state_n == S_ERR);
            illegal    <= accept && (state_n == S_DONE);
        end
    end

    // Latch the instruction fields and request payloads on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_NOP;
            frd_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_func_q   <= '0;
        end else if (accept) begin
            op_q  <= op;
            frd_q <= frd_addr;
            if (op == OP_FLW || op == OP_FSW) begin
                mem_addr_q  <= reg_rs1 + imm;
                mem_wdata_q <= freg_rs2;
            end
            if (op == OP_FARITH) begin
                fu_a_q    <= freg_rs1;
                fu_b_q    <= freg_rs2;
                fu_func_q <= fu_func;
            end
        end
    end

    // Write-back address/data; these hold after the enable pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freg_wb_addr <= '0;
            freg_wb_data <= '0;
            reg_wb_addr  <= '0;
            reg_wb_data  <= '0;
        end else begin
            if (ld_sample) begin
                freg_wb_addr <= frd_q;
                freg_wb_data <= bus.mem_rdata;
            end else if (fu_take) begin
                freg_wb_addr <= frd_q;
                freg_wb_data <= bus.fu_result;
            end else if (fmv_f) begin
                freg_wb_addr <= frd_addr;
                freg_wb_data <= reg_rs1;
            end
            if (fmv_x) begin
                reg_wb_addr <= rd_addr;
                reg_wb_data <= freg_rs1;
            end
        end
    end

    // Sticky exception flags; a clear coinciding with a result keeps only the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_acc <= '0;
        end else if (fflags_clr) begin
            fflags_acc <= fu_take ? bus.fu_flags : 5'd0;
        end else if (fu_take) begin
            fflags_acc <= fflags_acc | bus.fu_flags;
        end
    end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed self-checking bench for fpu_seq (default parameters).
module tb_fpu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enabled = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  fu_func = 2'd0;
    logic [31:0] reg_rs1 = '0, freg_rs1 = '0, freg_rs2 = '0, imm = '0;
    logic [4:0]  rd_addr = '0, frd_addr = '0;
    logic        fflags_clr = 1'b0;
    logic [4:0]  fflags_acc;
    logic        freg_wb_en, reg_wb_en, completed, mem_err, illegal, busy;
    logic [4:0]  freg_wb_addr, reg_wb_addr;
    logic [31:0] freg_wb_data, reg_wb_data;
    logic [3:0]  state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic        side_fx;

    fpu_seq_if #(.DW(32)) bus ();

    fpu_seq dut (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .op(op), .fu_func(fu_func),
        .reg_rs1(reg_rs1), .freg_rs1(freg_rs1), .freg_rs2(freg_rs2), .imm(imm),
        .rd_addr(rd_addr), .frd_addr(frd_addr), .bus(bus),
        .fflags_clr(fflags_clr), .fflags_acc(fflags_acc),
        .freg_wb_en(freg_wb_en), .freg_wb_addr(freg_wb_addr), .freg_wb_data(freg_wb_data),
        .reg_wb_en(reg_wb_en), .reg_wb_addr(reg_wb_addr), .reg_wb_data(reg_wb_data),
        .completed(completed), .mem_err(mem_err), .illegal(illegal), .busy(busy),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Driver: present one instruction for its accept cycle, then go quiet.
    task automatic issue(input logic [2:0] o, input logic [1:0] f, input logic [31:0] rs1,
                         input logic [31:0] fr1, input logic [31:0] fr2, input logic [31:0] im,
                         input logic [4:0] rd, input logic [4:0] frd);
        enabled = 1'b1; op = o; fu_func = f; reg_rs1 = rs1;
        freg_rs1 = fr1; freg_rs2 = fr2; imm = im; rd_addr = rd; frd_addr = frd;
        cyc();
        enabled = 1'b0; op = 3'd0;
    endtask

    // Driver: FU arithmetic with fu_done lat cycles after fu_start; ends in the WB cycle.
    task automatic farith(input logic [1:0] f, input logic [4:0] frd, input logic [31:0] res,
                          input logic [4:0] flg, input int lat, input logic clr);
        issue(3'd3, f, 32'h0, 32'h4000_0000, 32'h4040_0000, 32'h0, 5'd0, frd);
        repeat (lat) cyc();
        bus.fu_done = 1'b1; bus.fu_result = res; bus.fu_flags = flg; fflags_clr = clr;
        cyc();
        bus.fu_done = 1'b0; bus.fu_result = '0; bus.fu_flags = '0; fflags_clr = 1'b0;
    endtask

    // Scoreboard: every FP write-back must match the next expected value.
    always begin
        @(posedge clk);
        #1;
        if (freg_wb_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL sb_unexpected: observed 0x%08h expected none", freg_wb_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                assert (freg_wb_data === e) else begin
                    n_fail++;
                    $error("FAIL sb_fwb_data: observed 0x%08h expected 0x%08h", freg_wb_data, e);
                end
            end
        end
    end

    initial begin
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        bus.fu_done = 1'b0; bus.fu_result = '0; bus.fu_flags = '0;

        // Reset
        repeat (3) cyc();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {28'd0, state_dbg}, 32'd0);
        chk("rst_strobes", {29'd0, bus.mem_re, bus.mem_we, bus.fu_start}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // op=0 with enabled is ignored
        issue(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        chk("nop_busy", {31'd0, busy}, 32'd0);

        // FLW: mem_ready at T+2, data sampled at T+4, WB at T+5
        exp_q.push_back(32'h3F80_0000);
        issue(3'd1, 2'd0, 32'h100, 32'h0, 32'h0, 32'h8, 5'd0, 5'd3);
        chk("flw_re", {31'd0, bus.mem_re}, 32'd1);
        chk("flw_we", {31'd0, bus.mem_we}, 32'd0);
        chk("flw_addr", bus.mem_addr, 32'h108);
        cyc();
        chk("flw_re_low", {31'd0, bus.mem_re}, 32'd0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        enabled = 1'b1; op = 3'd2; reg_rs1 = 32'h999; imm = 32'h0;
        cyc();
        bus.mem_ready = 1'b0;
        enabled = 1'b0; op = 3'd0;
        chk("busy_addr_hold", bus.mem_addr, 32'h108);
        chk("busy_no_we", {31'd0, bus.mem_we}, 32'd0);
        chk("flw_t3_cmp", {31'd0, completed}, 32'd0);
        cyc();
        bus.mem_rdata = 32'h3F80_0000;
        chk("flw_t4_cmp", {31'd0, completed}, 32'd0);
        cyc();
        bus.mem_rdata = 32'h0;
        chk("flw_wb_en", {31'd0, freg_wb_en}, 32'd1);
        chk("flw_cmp", {31'd0, completed}, 32'd1);
        chk("flw_wb_addr", {27'd0, freg_wb_addr}, 32'd3);
        cyc();
        chk("flw_wb_pulse", {30'd0, freg_wb_en, completed}, 32'd0);
        chk("flw_data_hold", freg_wb_data, 32'h3F80_0000);
        chk("flw_idle", {31'd0, busy}, 32'd0);

        // FSW with address wrap and timeout after 16 MEM_WAIT cycles
        issue(3'd2, 2'd0, 32'hFFFF_FFFC, 32'h0, 32'h4049_0FDB, 32'h8, 5'd0, 5'd0);
        chk("fsw_we", {31'd0, bus.mem_we}, 32'd1);
        chk("fsw_re", {31'd0, bus.mem_re}, 32'd0);
        chk("fsw_addr_wrap", bus.mem_addr, 32'h4);
        chk("fsw_wdata", bus.mem_wdata, 32'h4049_0FDB);
        cyc();
        chk("fsw_we_low", {31'd0, bus.mem_we}, 32'd0);
        repeat (15) cyc();
        chk("tmo_last_wait", {31'd0, completed}, 32'd0);
        chk("tmo_last_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("tmo_cmp", {31'd0, completed}, 32'd1);
        chk("tmo_err", {31'd0, mem_err}, 32'd1);
        chk("tmo_no_wb", {30'd0, freg_wb_en, reg_wb_en}, 32'd0);
        cyc();
        chk("tmo_pulse", {30'd0, completed, mem_err}, 32'd0);

        // FSW with mem_ready in the 16th MEM_WAIT cycle: ready wins
        issue(3'd2, 2'd0, 32'h200, 32'h0, 32'h1111_2222, 32'h0, 5'd0, 5'd0);
        repeat (16) cyc();
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
        chk("edge_cmp", {31'd0, completed}, 32'd1);
        chk("edge_no_err", {31'd0, mem_err}, 32'd0);
        cyc();

        // FARITH: launch pulse, latched operands, done 4 cycles after start
        exp_q.push_back(32'h40C0_0000);
        issue(3'd3, 2'd2, 32'h0, 32'h4000_0000, 32'h4080_0000, 32'h0, 5'd0, 5'd5);
        chk("fu_start", {31'd0, bus.fu_start}, 32'd1);
        chk("fu_func_o", {30'd0, bus.fu_func_o}, 32'd2);
        chk("fu_a", bus.fu_a, 32'h4000_0000);
        chk("fu_b", bus.fu_b, 32'h4080_0000);
        cyc();
        chk("fu_start_low", {31'd0, bus.fu_start}, 32'd0);
        repeat (3) cyc();
        bus.fu_done = 1'b1; bus.fu_result = 32'h40C0_0000; bus.fu_flags = 5'h01;
        cyc();
        bus.fu_done = 1'b0; bus.fu_result = '0; bus.fu_flags = '0;
        chk("fa_wb_en", {31'd0, freg_wb_en}, 32'd1);
        chk("fa_wb_addr", {27'd0, freg_wb_addr}, 32'd5);
        chk("fa_cmp", {31'd0, completed}, 32'd1);
        chk("fa_flags1", {27'd0, fflags_acc}, 32'h01);
        cyc();

        exp_q.push_back(32'h40A0_0000);
        farith(2'd0, 5'd6, 32'h40A0_0000, 5'h04, 4, 1'b0);
        chk("fa_flags2", {27'd0, fflags_acc}, 32'h05);
        cyc();

        exp_q.push_back(32'h4100_0000);
        farith(2'd1, 5'd7, 32'h4100_0000, 5'h10, 2, 1'b1);
        chk("fa_clr_done", {27'd0, fflags_acc}, 32'h10);
        cyc();

        // fu_done outside FU_WAIT is ignored
        bus.fu_done = 1'b1; bus.fu_result = 32'hBAD0_BAD0; bus.fu_flags = 5'h08;
        cyc();
        bus.fu_done = 1'b0; bus.fu_result = '0; bus.fu_flags = '0;
        chk("stray_done_flags", {27'd0, fflags_acc}, 32'h10);
        chk("stray_done_busy", {31'd0, busy}, 32'd0);
        fflags_clr = 1'b1;
        cyc();
        fflags_clr = 1'b0;
        chk("flags_clr", {27'd0, fflags_acc}, 32'h00);

        // FMV pair, back-to-back
        issue(3'd4, 2'd0, 32'h0, 32'hC000_0000, 32'h0, 32'h0, 5'd7, 5'd0);
        chk("fmvx_en", {31'd0, reg_wb_en}, 32'd1);
        chk("fmvx_addr", {27'd0, reg_wb_addr}, 32'd7);
        chk("fmvx_data", reg_wb_data, 32'hC000_0000);
        chk("fmvx_cmp", {31'd0, completed}, 32'd1);
        chk("fmvx_no_fwb", {31'd0, freg_wb_en}, 32'd0);
        cyc();
        chk("fmv_gap_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(32'h1234_5678);
        issue(3'd5, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9);
        chk("fmvw_en", {31'd0, freg_wb_en}, 32'd1);
        chk("fmvw_addr", {27'd0, freg_wb_addr}, 32'd9);
        chk("fmvx_data_hold", reg_wb_data, 32'hC000_0000);
        cyc();

        // Illegal ops 6 and 7
        issue(3'd6, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd1);
        chk("ill6_flags", {29'd0, completed, illegal, mem_err}, 32'b110);
        chk("ill6_no_wr", {28'd0, freg_wb_en, reg_wb_en, bus.mem_re, bus.mem_we}, 32'd0);
        cyc();
        chk("ill6_pulse", {31'd0, illegal}, 32'd0);
        issue(3'd7, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd1);
        chk("ill7_flags", {29'd0, completed, illegal, mem_err}, 32'b110);
        cyc();

        // Reset during FLW MEM_WAIT aborts the instruction
        issue(3'd1, 2'd0, 32'h300, 32'h0, 32'h0, 32'h4, 5'd0, 5'd2);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_addr", bus.mem_addr, 32'h0);
        chk("arst_fwb_data", freg_wb_data, 32'h0);
        chk("arst_xwb_data", reg_wb_data, 32'h0);
        chk("arst_pulses", {27'd0, completed, mem_err, illegal, freg_wb_en, reg_wb_en}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        cyc();
        bus.mem_ready = 1'b0;
        side_fx = 1'b0;
        for (int i = 0; i < 6; i++) begin
            side_fx = side_fx | completed | freg_wb_en | busy;
            cyc();
        end
        chk("arst_no_completion", {31'd0, side_fx}, 32'd0);

        // Final report
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
Parametrised successor to the single-issue FPU controller. It sequences FLW, FSW, generic floating-point arithmetic (add/sub/mul/div via an external pipelined functional unit), and the FMV.X.W / FMV.W.X register moves. It adds a memory timeout with an error report, a configurable load-sample delay, and a sticky exception-flag accumulator. It sits between the decode stage, the data-memory port, the FP functional unit, and both register-file write ports.

Parameters:
DW, 32, data/address width (mem_addr = low DW bits of reg_rs1+imm)
RA, 5, register address width
MEM_TIMEOUT, 16, max cycles in MEM_WAIT without mem_ready before error (>=1)
LD_SAMPLE_DLY, 2, cycles between mem_ready and the mem_rdata sample (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
enabled  in  1  instruction valid; sampled only in IDLE
op  in  3  0 NOP, 1 FLW, 2 FSW, 3 FARITH, 4 FMV_X_W, 5 FMV_W_X, 6-7 illegal
fu_func  in  2  arithmetic function, forwarded unchanged to the FU
reg_rs1  in  DW  integer source (base address / FMV_W_X data)
freg_rs1, freg_rs2  in  DW  FP sources
imm  in  DW  address offset
rd_addr, frd_addr  in  RA  integer / FP destinations
mem_addr, mem_wdata  out  DW  memory request
mem_re, mem_we  out  1  read / write strobes
mem_rdata  in  DW  read data
mem_ready  in  1  memory acknowledge
fu_start  out  1  FU launch pulse
fu_func_o  out  2  latched function
fu_a, fu_b  out  DW  latched operands
fu_done  in  1  FU result valid
fu_result  in  DW  FU result
fu_flags  in  5  NV,DZ,OF,UF,NX, valid with fu_done
fflags_clr  in  1  clear the accumulator
fflags_acc  out  5  sticky OR of fu_flags
freg_wb_en  out  1  FP write enable
freg_wb_addr  out  RA  FP write address
freg_wb_data  out  DW  FP write data
reg_wb_en  out  1  integer write enable
reg_wb_addr  out  RA  integer write address
reg_wb_data  out  DW  integer write data
completed  out  1  one-cycle end-of-instruction pulse
mem_err  out  1  timeout flag, pulsed with completed
illegal  out  1  illegal-op flag, pulsed with completed
busy  out  1  state != IDLE (combinational)

Behaviour:
- States: IDLE, MEM_REQ, MEM_WAIT, LD_DLY, FU_START, FU_WAIT, WB, DONE, ERR.
- Reset: every output register is 0 and the state is IDLE. A reset mid-operation aborts the instruction; no writeback or completed pulse follows.
- Accept: an instruction is accepted in IDLE when enabled=1 and op!=0.
  - On acceptance, latch op, fu_func, operands, destinations, and addr=(reg_rs1+imm) mod 2^DW.
  - Inputs are ignored while busy. enabled with op=0 is ignored.
- Strobe timing: mem_re and mem_we are high only during the MEM_REQ cycle. fu_start is high only during FU_START. Strobes are registered and glitch-free.
- mem_addr, mem_wdata, fu_a, fu_b and fu_func_o hold their latched values from MEM_REQ/FU_START until the next accept.
- FLW: IDLE -> MEM_REQ(mem_re) -> MEM_WAIT.
  - MEM_WAIT exits on mem_ready to LD_DLY, or directly to WB if LD_SAMPLE_DLY=0 (in that case mem_rdata is sampled the same cycle).
  - LD_DLY counts LD_SAMPLE_DLY cycles and samples mem_rdata in its last cycle.
  - WB: freg_wb_en=1 with frd_addr and the sampled data; completed=1. Then IDLE.
  - Latency with mem_ready in the first MEM_WAIT cycle: completed at T+3+LD_SAMPLE_DLY, where T is the accept cycle.
- FSW: MEM_REQ(mem_we, mem_wdata=freg_rs2) -> MEM_WAIT -> on mem_ready DONE (completed=1) -> IDLE. No writeback.
- Timeout: a cycle counter runs in MEM_WAIT.
  - After MEM_TIMEOUT consecutive cycles without mem_ready, go to ERR: completed=1, mem_err=1, no writeback. Then IDLE.
  - mem_ready in the final counted cycle wins over the timeout.
  - mem_ready outside MEM_WAIT is ignored.
- FARITH: FU_START -> FU_WAIT (no timeout) -> on fu_done capture fu_result -> WB with freg_wb_en to frd_addr. fu_done outside FU_WAIT is ignored.
- fflags_acc: on an accepted fu_done, fflags_acc |= fu_flags. fflags_clr sets it to 0. If fflags_clr coincides with fu_done, fflags_acc = fu_flags.
- FMV_X_W: T+1 WB: reg_wb_en=1, reg_wb_addr=rd_addr, reg_wb_data=freg_rs1, completed=1.
- FMV_W_X: T+1 WB: freg_wb_en=1, freg_wb_data=reg_rs1.
- Illegal op (6, 7): T+1 DONE with completed=1, illegal=1, no side effects.
- Pulse width: all write enables, completed, mem_err and illegal are exactly one cycle. The write-back address and data hold their values after the pulse.
- Back-to-back: a new instruction can be accepted in the cycle after completed.

Test Plan:
- FLW: reg_rs1=0x100, imm=0x8, frd=3, LD_SAMPLE_DLY=2, mem_ready at T+2, mem_rdata=0x3F800000 -> mem_addr=0x108, mem_re high only at T+1, freg_wb_en and completed at T+5, f3=0x3F800000.
- FSW timeout: reg_rs1=0xFFFFFFFC, imm=0x8, freg_rs2=0x40490FDB, mem_ready never asserted -> mem_addr=0x00000004 (wrap), mem_we high 1 cycle, ERR after 16 MEM_WAIT cycles, completed=1 and mem_err=1, no writeback.
- FARITH: fu_func=2, fu_done 4 cycles after fu_start with result 0x40C00000 and flags 0x01, then a second op with flags 0x04 -> frd written 0x40C00000, fflags_acc=0x05. Assert fflags_clr alongside a third fu_done with flags 0x10 -> fflags_acc=0x10.
- FMV pair: FMV_X_W with freg_rs1=0xC0000000, rd=7, then FMV_W_X with reg_rs1=0x12345678, frd=9 -> x7=0xC0000000 at T+1, f9=0x12345678 two cycles later, busy low between them.
- Robustness: op=6 -> completed=1, illegal=1, no write enables. Assert rst_n low during FLW MEM_WAIT -> all outputs 0 immediately, no completed after release. Change inputs while busy -> latched values unchanged.
